// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the ROM address and registers the
// fetched instruction into a one-entry output stage with valid/ready handshake.
module fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR = '1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_instr,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic                   busy,
    output logic                   halted
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHalt = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  opc_q, opc_d;
    logic                   fetch_en;

    assign fetch_en = !valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                // A redirect squashes both the held output and this cycle's fetch, HALT included.
                if (redirect_valid) begin
                    pc_d    = redirect_addr;
                    valid_d = 1'b0;
                end else if (fetch_en) begin
                    instr_d = rom_instr;
                    opc_d   = pc_q;
                    valid_d = 1'b1;
                    if (rom_instr == HALT_INSTR) begin
                        state_d = StHalt;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            StHalt: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = StRun;
                    valid_d = 1'b0;
                end else if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end

    assign rom_addr  = pc_q;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = opc_q;
    assign busy      = (state_q == StRun);
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural combinational ROM.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic        busy;
    logic        halted;

    logic [15:0] rom [256];
    int checks;
    int errors;

    assign rom_instr = rom[rom_addr];

    fetch_ctrl #(
        .ADDR_WIDTH (8),
        .INSTR_WIDTH(16),
        .RESET_PC   (8'h00),
        .HALT_INSTR (16'hFFFF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rom_addr      (rom_addr),
        .rom_instr     (rom_instr),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .busy          (busy),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
        if (rom_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h exp 00", rom_addr); end
        if (out_instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got %h exp 0000", out_instr); end
        if (out_pc !== 8'h00) begin errors++; $display("FAIL rst_pc got %h exp 00", out_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        // IDLE ignores redirect and ready.
        redirect_valid = 1'b1;
        redirect_addr  = 8'h33;
        tick();
        redirect_valid = 1'b0;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid); end
        if (rom_addr !== 8'h00) begin errors++; $display("FAIL idle_addr got %h exp 00", rom_addr); end
    endtask

    task automatic test_sequence();
        logic [15:0] exp_i [4];
        exp_i[0] = 16'h1111; exp_i[1] = 16'h2222; exp_i[2] = 16'h3333; exp_i[3] = 16'hFFFF;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy got %b exp 1", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_v0 got %b exp 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got %b exp 1", i, out_valid); end
            if (out_instr !== exp_i[i]) begin
                errors++; $display("FAIL seq_instr%0d got %h exp %h", i, out_instr, exp_i[i]);
            end
            if (out_pc !== 8'(i)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, out_pc, 8'(i)); end
        end
        checks += 3;
        if (halted !== 1'b1) begin errors++; $display("FAIL seq_halted got %b exp 1", halted); end
        if (busy !== 1'b0) begin errors++; $display("FAIL seq_nbusy got %b exp 0", busy); end
        if (rom_addr !== 8'h03) begin errors++; $display("FAIL seq_haddr got %h exp 03", rom_addr); end
        tick();
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL seq_drain got %b exp 0", out_valid); end
        if (rom_addr !== 8'h03) begin errors++; $display("FAIL seq_hold got %h exp 03", rom_addr); end
        if (halted !== 1'b1) begin errors++; $display("FAIL seq_hstay got %b exp 1", halted); end
    endtask

    task automatic test_backpressure_redirect();
        // Restart from HALT, then stall on the entry at pc 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy got %b exp 1", busy); end
        if (rom_addr !== 8'h00) begin errors++; $display("FAIL rs_addr got %h exp 00", rom_addr); end
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %b exp 1", i, out_valid); end
            if (out_instr !== 16'h2222) begin errors++; $display("FAIL bp_instr%0d got %h exp 2222", i, out_instr); end
            if (out_pc !== 8'h01) begin errors++; $display("FAIL bp_pc%0d got %h exp 01", i, out_pc); end
            if (rom_addr !== 8'h02) begin errors++; $display("FAIL bp_addr%0d got %h exp 02", i, rom_addr); end
        end
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_pc !== 8'h02) begin errors++; $display("FAIL bp_next_pc got %h exp 02", out_pc); end
        if (out_instr !== 16'h3333) begin errors++; $display("FAIL bp_next_i got %h exp 3333", out_instr); end
        // Redirect while stalled; rom_instr is FFFF at pc 3 this cycle as well.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 8'h40;
        tick();
        redirect_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got %b exp 0", out_valid); end
        if (rom_addr !== 8'h40) begin errors++; $display("FAIL rd_addr got %h exp 40", rom_addr); end
        if (halted !== 1'b0) begin errors++; $display("FAIL rd_halted got %b exp 0", halted); end
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_pc !== 8'h40) begin errors++; $display("FAIL rd_pc got %h exp 40", out_pc); end
        if (out_instr !== 16'h1040) begin errors++; $display("FAIL rd_instr got %h exp 1040", out_instr); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [4];
        logic [15:0] exp_i [4];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00; exp_pc[3] = 8'h01;
        exp_i[0] = 16'h10FE; exp_i[1] = 16'h10FF; exp_i[2] = 16'h1111; exp_i[3] = 16'h2222;
        redirect_valid = 1'b1;
        redirect_addr  = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 2;
            if (out_pc !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc%0d got %h exp %h", i, out_pc, exp_pc[i]); end
            if (out_instr !== exp_i[i]) begin
                errors++; $display("FAIL wrap_i%0d got %h exp %h", i, out_instr, exp_i[i]);
            end
        end
    endtask

    task automatic test_redirect_halt();
        redirect_valid = 1'b1;
        redirect_addr  = 8'h80;
        tick();
        // Now pc=80 presents FFFF; redirect coincides with it.
        redirect_addr = 8'h20;
        tick();
        redirect_valid = 1'b0;
        checks += 4;
        if (halted !== 1'b0) begin errors++; $display("FAIL rh_halted got %b exp 0", halted); end
        if (busy !== 1'b1) begin errors++; $display("FAIL rh_busy got %b exp 1", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rh_valid got %b exp 0", out_valid); end
        if (rom_addr !== 8'h20) begin errors++; $display("FAIL rh_addr got %h exp 20", rom_addr); end
        tick();
        checks += 2;
        if (out_pc !== 8'h20) begin errors++; $display("FAIL rh_pc got %h exp 20", out_pc); end
        if (out_instr !== 16'h1020) begin errors++; $display("FAIL rh_instr got %h exp 1020", out_instr); end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b exp 0", busy); end
        if (rom_addr !== 8'h00) begin errors++; $display("FAIL ar_addr got %h exp 00", rom_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // start wins over a simultaneous redirect in IDLE.
        start          = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 8'h55;
        tick();
        start          = 1'b0;
        redirect_valid = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL ar_start got %b exp 1", busy); end
        if (rom_addr !== 8'h00) begin errors++; $display("FAIL ar_rdign got %h exp 00", rom_addr); end
        tick();
        checks += 2;
        if (out_pc !== 8'h00) begin errors++; $display("FAIL ar_pc got %h exp 00", out_pc); end
        if (out_instr !== 16'h1111) begin errors++; $display("FAIL ar_instr got %h exp 1111", out_instr); end
    endtask

    task automatic test_halt_restart();
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        checks += 2;
        if (halted !== 1'b1) begin errors++; $display("FAIL hr_halted got %b exp 1", halted); end
        if (out_instr !== 16'hFFFF) begin errors++; $display("FAIL hr_instr got %h exp FFFF", out_instr); end
        redirect_valid = 1'b1;
        redirect_addr  = 8'h77;
        tick();
        redirect_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL hr_pend got %b exp 1", out_valid); end
        if (rom_addr !== 8'h03) begin errors++; $display("FAIL hr_addr got %h exp 03", rom_addr); end
        if (out_pc !== 8'h03) begin errors++; $display("FAIL hr_opc got %h exp 03", out_pc); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks += 3;
        if (busy !== 1'b1) begin errors++; $display("FAIL hr_busy got %b exp 1", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL hr_disc got %b exp 0", out_valid); end
        if (rom_addr !== 8'h00) begin errors++; $display("FAIL hr_raddr got %h exp 00", rom_addr); end
        out_ready = 1'b1;
        tick();
        checks += 2;
        if (out_pc !== 8'h00) begin errors++; $display("FAIL hr_pc got %h exp 00", out_pc); end
        if (out_instr !== 16'h1111) begin errors++; $display("FAIL hr_i got %h exp 1111", out_instr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
        rom[0] = 16'h1111;
        rom[1] = 16'h2222;
        rom[2] = 16'h3333;
        rom[3] = 16'hFFFF;
        rom[8'h80] = 16'hFFFF;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;
        out_ready      = 1'b0;
        rst_n          = 1'b1;
        #1;
        test_reset();
        test_sequence();
        test_backpressure_redirect();
        test_wrap();
        test_redirect_halt();
        test_async_reset();
        test_halt_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
